// File: rtl/ysyx_22050039_ifu_if.sv
// rtl/ysyx_22050039_ifu_if.sv - fetch unit memory request/response and downstream instruction handshake bundle
//
// Signal groups:
//   mem_req_*   fetch request, driven by the fetch unit (valid/ready)
//   mem_resp_*  read data, returned by memory (one pulse per accepted request)
//   out_*       instruction handed to decode/execute (valid/ready)
// Modports:
//   master  the fetch unit's view
//   slave   the memory + downstream view
interface ysyx_22050039_ifu_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [XLEN-1:0]     mem_req_addr;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_resp_data;
    logic                out_valid;
    logic                out_ready;
    logic [INST_LEN-1:0] out_inst;
    logic [XLEN-1:0]     out_pc;
    logic                out_fault;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output out_valid, out_inst, out_pc, out_fault,
        input  out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  out_valid, out_inst, out_pc, out_fault,
        output out_ready
    );
endinterface

// File: rtl/ysyx_22050039_ifu.sv
// rtl/ysyx_22050039_ifu.sv - instruction fetch unit: owns the PC, one outstanding doubleword fetch, redirect handling
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst             asynchronous active-low reset
//   redirect_valid  execute requests a PC redirect this cycle
//   redirect_pc     redirect target (dnpc)
//   bus             ysyx_22050039_ifu_if.master: memory request/response and downstream {inst, pc, fault}
module ysyx_22050039_ifu #(
    parameter int                 XLEN     = 64,
    parameter int                 INST_LEN = 32,
    parameter logic [XLEN-1:0]    RESET_PC = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    ysyx_22050039_ifu_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    state_t              state, state_n;
    logic [XLEN-1:0]     pc, pc_n;
    logic                drop, drop_n;
    logic                capture;
    logic [INST_LEN-1:0] out_inst_q;
    logic [XLEN-1:0]     out_pc_q;
    logic [INST_LEN-1:0] inst_sel;

    // Any freshly loaded PC is alignment-checked before a fetch is issued.
    function automatic state_t entry_state(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00) ? FAULT : REQ;
    endfunction

    assign inst_sel = pc[2] ? bus.mem_resp_data[2*INST_LEN-1:INST_LEN]
                            : bus.mem_resp_data[INST_LEN-1:0];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = entry_state(redirect_pc);
                end else begin
                    state_n = entry_state(pc);
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (bus.mem_req_ready) begin
                        // Old request already accepted: its response must be swallowed.
                        drop_n  = 1'b1;
                        state_n = WAIT;
                    end else begin
                        state_n = entry_state(redirect_pc);
                    end
                end else if (bus.mem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (bus.mem_resp_valid) begin
                        drop_n  = 1'b0;
                        state_n = entry_state(redirect_pc);
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (bus.mem_resp_valid) begin
                    if (drop) begin
                        // pc already holds the redirect target, which may be misaligned.
                        drop_n  = 1'b0;
                        state_n = entry_state(pc);
                    end else begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // Redirect wins over a simultaneous accept; no sequential advance.
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = entry_state(redirect_pc);
                end else if (bus.out_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = REQ;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = entry_state(redirect_pc);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            out_inst_q <= '0;
            out_pc_q   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
            if (capture) begin
                out_inst_q <= inst_sel;
                out_pc_q   <= pc;
            end else if (state_n == FAULT) begin
                out_pc_q <= pc_n;
            end
        end
    end

    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = {pc[XLEN-1:3], 3'b000};
    assign bus.out_valid     = (state == HOLD) || (state == FAULT);
    assign bus.out_fault     = (state == FAULT);
    assign bus.out_inst      = out_inst_q;
    assign bus.out_pc        = out_pc_q;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// tb/tb_ysyx_22050039_ifu.sv - scoreboard testbench for ysyx_22050039_ifu
module tb_ysyx_22050039_ifu;
    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;

    ysyx_22050039_ifu_if #(.XLEN(XLEN), .INST_LEN(INST_LEN)) bus ();

    ysyx_22050039_ifu #(
        .XLEN     (XLEN),
        .INST_LEN (INST_LEN),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0010_0073;
        return {a[31:0] ^ 32'h1357_9bdf, a[31:0] ^ 32'h2468_ace0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request_accept(input logic [63:0] exp_addr);
        int n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        check("req_addr", bus.mem_req_addr, exp_addr);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("req_off_in_wait", {63'd0, bus.mem_req_valid}, 64'd0);
    endtask

    task automatic respond(input logic [63:0] addr, input logic [63:0] exp_pc, input bit push);
        logic [63:0] d;
        exp_t        e;
        d = mem_data(addr);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = d;
        if (push) begin
            e.inst = exp_pc[2] ? d[63:32] : d[31:0];
            e.pc   = exp_pc;
            sb.push_back(e);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic issue(input logic [63:0] exp_addr, input logic [63:0] exp_pc);
        request_accept(exp_addr);
        respond(exp_addr, exp_pc, 1'b1);
    endtask

    task automatic accept();
        exp_t e;
        check("out_valid", {63'd0, bus.out_valid}, 64'd1);
        check("out_fault_clear", {63'd0, bus.out_fault}, 64'd0);
        check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_inst", {32'd0, bus.out_inst}, {32'd0, e.inst});
            check("out_pc", bus.out_pc, e.pc);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.out_ready      = 1'b0;

        tick();
        tick();
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst_out_inst", {32'd0, bus.out_inst}, 64'd0);
        check("rst_out_pc", bus.out_pc, 64'd0);
        check("rst_out_fault", {63'd0, bus.out_fault}, 64'd0);
        rst = 1'b1;

        // Both halves of the first doubleword, lower then upper.
        issue(64'h8000_0000, 64'h8000_0000);
        accept();
        issue(64'h8000_0000, 64'h8000_0004);
        accept();

        // Downstream stall in HOLD.
        issue(64'h8000_0008, 64'h8000_0008);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
            check("hold_inst", {32'd0, bus.out_inst}, {32'd0, sb[0].inst});
            check("hold_pc", bus.out_pc, sb[0].pc);
            check("hold_no_req", {63'd0, bus.mem_req_valid}, 64'd0);
            tick();
        end
        accept();

        // Redirect while waiting; the late response is dropped.
        request_accept(64'h8000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("drop_wait_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();
        respond(64'h8000_0008, 64'h8000_000c, 1'b0);
        check("drop_no_out", {63'd0, bus.out_valid}, 64'd0);
        issue(64'h8000_0100, 64'h8000_0100);
        accept();

        // Redirect in HOLD beats a simultaneous accept.
        issue(64'h8000_0100, 64'h8000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0020;
        bus.out_ready  = 1'b1;
        tick();
        redirect_valid = 1'b0;
        bus.out_ready  = 1'b0;
        e = sb.pop_front();
        check("hold_redir_discard", {63'd0, bus.out_valid}, 64'd0);
        issue(64'h8000_0020, 64'h8000_0020);
        accept();

        // Misaligned redirect from REQ (not accepted) -> FAULT, sticky under out_ready.
        check("pre_fault_req", {63'd0, bus.mem_req_valid}, 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        check("fault_valid", {63'd0, bus.out_valid}, 64'd1);
        check("fault_flag", {63'd0, bus.out_fault}, 64'd1);
        check("fault_pc", bus.out_pc, 64'h8000_0002);
        check("fault_no_req", {63'd0, bus.mem_req_valid}, 64'd0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("fault_sticky", {63'd0, bus.out_fault}, 64'd1);
        check("fault_sticky_no_req", {63'd0, bus.mem_req_valid}, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        check("fault_cleared", {63'd0, bus.out_fault}, 64'd0);
        issue(64'h8000_0008, 64'h8000_0008);
        accept();

        // Redirect in REQ with no acceptance, then PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffc;
        tick();
        redirect_valid = 1'b0;
        issue(64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_fffc);
        accept();
        issue(64'h0, 64'h0);
        accept();

        // Asynchronous reset in WAIT, stray response afterwards.
        request_accept(64'h0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        check("arst_out_pc", bus.out_pc, 64'd0);
        tick();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hdead_beef_cafe_f00d;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        check("stray_ignored", {63'd0, bus.out_valid}, 64'd0);
        issue(64'h8000_0000, 64'h8000_0000);
        accept();

        check("sb_drained", sb.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
